// File: rtl/padd_pkg.sv
// Shared types and default sizing for the pipelined-adder scheduler.
package padd_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/padd_sched_if.sv
// Requester/response bus for padd_sched: two requesters in, one result bus out.
interface padd_sched_if import padd_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             Valid0, Valid1;
  logic             Ready0, Ready1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic             CI0, CI1;
  logic             RspValid;
  logic             RspId;
  logic [WIDTH-1:0] RspS;
  logic             RspCO;

  modport master (
    output Valid0, Valid1, A0, B0, CI0, A1, B1, CI1,
    input  Ready0, Ready1, RspValid, RspId, RspS, RspCO
  );

  modport slave (
    input  Valid0, Valid1, A0, B0, CI0, A1, B1, CI1,
    output Ready0, Ready1, RspValid, RspId, RspS, RspCO
  );

endinterface

// File: rtl/padd_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module padd_rr_arb (
  input  logic Clock,
  input  logic Reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr names the requester that wins when both request
  logic ptr;

  always_comb begin
    gnt0 = '0;
    gnt1 = '0;
    if (en) begin
      if (req0 && (!req1 || !ptr)) gnt0 = '1;
      else if (req1)               gnt1 = '1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     ptr <= '0;
    else if (gnt0) ptr <= '1;
    else if (gnt1) ptr <= '0;
  end

endmodule

// File: rtl/padd_sched.sv
// Schedules two requesters onto one shared pipelined adder and returns tagged results.
// Optional PADD_SCHED_STATS_EN adds per-requester issue counts and a stall counter.
module padd_sched import padd_pkg::*; #(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                            Clock,
  input  logic                            Reset,
  padd_sched_if.slave                     bus,
  output logic [WIDTH-1:0]                AddA,
  output logic [WIDTH-1:0]                AddB,
  output logic                            AddCI,
  input  logic [WIDTH-1:0]                AddS,
  input  logic                            AddCO,
  input  logic                            Drain,
  output logic                            DrainDone,
  output logic [$clog2(LATENCY+2)-1:0]    InFlight
`ifdef PADD_SCHED_STATS_EN
  ,
  output logic [31:0]                     IssueCnt0,
  output logic [31:0]                     IssueCnt1,
  output logic [31:0]                     StallCnt
`endif
);

  localparam int unsigned IFW = $clog2(LATENCY+2);

  sched_state_t          state, next_state;
  logic                  issue_en, gnt0, gnt1, accept;
  tag_t [LATENCY:0]      tag_q;
  tag_t                  rsp_tag;

  // Drain gates grants in the same cycle it appears, before the state catches up
  assign issue_en = (state != DRAIN) && !Drain && !Reset;

  padd_rr_arb u_arb (
    .Clock (Clock),
    .Reset (Reset),
    .en    (issue_en),
    .req0  (bus.Valid0),
    .req1  (bus.Valid1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign bus.Ready0 = gnt0;
  assign bus.Ready1 = gnt1;
  assign accept     = gnt0 | gnt1;
  assign rsp_tag    = tag_q[LATENCY];
  assign DrainDone  = (state == DRAIN) && (InFlight == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (Drain) begin
      next_state = DRAIN;
    end else begin
      unique case (state)
        IDLE:    if (bus.Valid0 || bus.Valid1) next_state = ISSUE;
        ISSUE:   if (!bus.Valid0 && !bus.Valid1 && InFlight == '0) next_state = IDLE;
        DRAIN:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      AddA  <= '0;
      AddB  <= '0;
      AddCI <= '0;
    end else if (accept) begin
      AddA  <= gnt1 ? bus.A1  : bus.A0;
      AddB  <= gnt1 ? bus.B1  : bus.B0;
      AddCI <= gnt1 ? bus.CI1 : bus.CI0;
    end
  end

  // The last tag stage lines up with the adder output one edge after it settles
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) tag_q <= '0;
    else       tag_q <= {tag_q[LATENCY-1:0], tag_t'{valid: accept, id: gnt1}};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.RspValid <= '0;
      bus.RspId    <= '0;
      bus.RspS     <= '0;
      bus.RspCO    <= '0;
    end else begin
      bus.RspValid <= rsp_tag.valid;
      if (rsp_tag.valid) begin
        bus.RspId <= rsp_tag.id;
        bus.RspS  <= AddS;
        bus.RspCO <= AddCO;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      InFlight <= '0;
    end else begin
      unique case ({accept, rsp_tag.valid})
        2'b10:   InFlight <= InFlight + IFW'(1);
        2'b01:   InFlight <= InFlight - IFW'(1);
        default: InFlight <= InFlight;
      endcase
    end
  end

`ifdef PADD_SCHED_STATS_EN
  logic stall0, stall1;
  assign stall0 = bus.Valid0 & ~gnt0;
  assign stall1 = bus.Valid1 & ~gnt1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      IssueCnt0 <= '0;
      IssueCnt1 <= '0;
      StallCnt  <= '0;
    end else begin
      if (gnt0) IssueCnt0 <= IssueCnt0 + 32'd1;
      if (gnt1) IssueCnt1 <= IssueCnt1 + 32'd1;
      StallCnt <= StallCnt + 32'(stall0) + 32'(stall1);
    end
  end
`endif

endmodule
